// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the programmable multi-channel divider.
// Shared by the channel slice and the top-level write decode.
package clk_gen_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int MIN_DIV   = 2;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic [DEF_CNT_W-1:0] high;
  } clk_cfg_t;

  // Periods below two cycles cannot show a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active config, idle/run control.
// All outputs come straight from flops.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_pend,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;

  cfg_t             act;
  cfg_t             shd;
  cfg_t             wr;
  cfg_t             src;
  cfg_t             nxt_act;
  cfg_t             nxt_shd;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_pend;
  logic             nxt_run;
  logic             nxt_tick;
  logic             nxt_clk;
  logic             wrap;
  logic             apply;

  always_comb begin
    wr       = '{div: cfg_div, high: cfg_high};
    src      = cfg_we ? wr : shd;
    wrap     = running && (cnt >= act.div - 1'b1);
    apply    = !running || sync || wrap;
    nxt_act  = act;
    nxt_shd  = shd;
    nxt_pend = cfg_pend;
    nxt_cnt  = '0;
    nxt_run  = 1'b0;
    nxt_tick = 1'b0;
    nxt_clk  = 1'b0;
    if (cfg_we)
      nxt_shd = wr;
    // A write landing on an apply edge goes live without ever pending.
    if ((cfg_we || cfg_pend) && apply) begin
      nxt_act.div  = CNT_W'(clamp_div(32'(src.div)));
      nxt_act.high = src.high;
      nxt_pend     = 1'b0;
    end else if (cfg_we) begin
      nxt_pend = 1'b1;
    end
    if (en) begin
      nxt_run  = 1'b1;
      nxt_cnt  = apply ? '0 : cnt + 1'b1;
      nxt_tick = (nxt_cnt == '0);
      nxt_clk  = (nxt_cnt < nxt_act.high);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act.div  <= CNT_W'(clamp_div(32'(DEFAULT_DIV)));
      act.high <= CNT_W'(DEFAULT_HIGH);
      shd      <= '0;
      cnt      <= '0;
      cfg_pend <= 1'b0;
      running  <= 1'b0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      act      <= nxt_act;
      shd      <= nxt_shd;
      cnt      <= nxt_cnt;
      cfg_pend <= nxt_pend;
      running  <= nxt_run;
      tick     <= nxt_tick;
      clk_out  <= nxt_clk;
    end
  end

endmodule

// File: rtl/multi_clk_div_gen.sv
// Multi-channel programmable clock divider / tick generator.
// Top decodes config writes and fans SYNC out to every channel.
module multi_clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              CFG_WE,
  input  logic [SEL_W-1:0]  CFG_SEL,
  input  logic [CNT_W-1:0]  CFG_DIV,
  input  logic [CNT_W-1:0]  CFG_HIGH,
  output logic [NUM_CH-1:0] CFG_PEND,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] RUNNING
);

  logic [NUM_CH-1:0] ch_we;

  // Indices past NUM_CH match no channel, so such writes vanish.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_we[i] = CFG_WE && (CFG_SEL == SEL_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RESETN),
      .en      (EN[g]),
      .sync    (SYNC),
      .cfg_we  (ch_we[g]),
      .cfg_div (CFG_DIV),
      .cfg_high(CFG_HIGH),
      .cfg_pend(CFG_PEND[g]),
      .clk_out (CLK_OUT[g]),
      .tick    (TICK[g]),
      .running (RUNNING[g])
    );
  end

endmodule
